keypad_bcd_scanner: RTL

KEYPAD_BCD_SCANNER -- requirements
Module: keypad_bcd_scanner

---
 rtl/keypad_bcd_scanner.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/keypad_bcd_scanner.sv
// Debounced one-hot keypad to BCD digit queue; a stable press is pushed DEBOUNCE_CYCLES+1 cycles after first sample.
// Consumer pops with valid&&ready; a push into a full queue with no pop is dropped and latches overflow.
module keypad_bcd_scanner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    dec,
  input  logic                          ready,
  input  logic                          clr_ovf,
  output logic [3:0]                    bcd,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          multi_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    EMIT,
    WAIT_RELEASE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [9:0]  key_q;
  logic [9:0]  key_nxt;
  logic        multi_nxt;
  logic        push;
  logic [8:0]  cnt_inc;
  logic        cnt_hit;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          full;
  logic          wr_en;

  function automatic logic [3:0] key_to_bcd(input logic [9:0] k);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) code = 4'(i);
    end
    return code;
  endfunction

  assign cnt_inc = {1'b0, cnt} + 9'd1;
  assign cnt_hit = (cnt_inc == 9'(DEBOUNCE_CYCLES));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      key_q     <= 10'd0;
      multi_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      key_q     <= key_nxt;
      multi_err <= multi_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    key_nxt   = key_q;
    multi_nxt = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (dec != 10'd0) begin
          cnt_nxt = 8'd0;
          if ($onehot(dec)) begin
            key_nxt   = dec;
            state_nxt = DEBOUNCE;
          end else begin
            multi_nxt = 1'b1;
            state_nxt = WAIT_RELEASE;
          end
        end
      end
      DEBOUNCE: begin
        if (dec == key_q) begin
          if (cnt_hit) begin
            cnt_nxt   = 8'd0;
            state_nxt = EMIT;
          end else begin
            cnt_nxt = cnt_inc[7:0];
          end
        end else begin
          // a bounce simply abandons the candidate without reporting anything
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end
      end
      EMIT: begin
        push      = 1'b1;
        cnt_nxt   = 8'd0;
        state_nxt = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (dec != 10'd0) begin
          cnt_nxt = 8'd0;
        end else if (cnt_hit) begin
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc[7:0];
        end
      end
      default: begin
        cnt_nxt   = 8'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign valid = (level != LW'(0));
  assign bcd   = mem[rd_ptr];
  assign pop   = valid & ready;
  assign full  = (level == LW'(FIFO_DEPTH));
  // when full, the simultaneous pop frees the slot the push lands in
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 4'd0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= key_to_bcd(key_q);
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
